// File: rtl/eth_port_arbiter.sv
// Four-port packet-granular round-robin arbiter with zero-latency pass-through.
// Define ETH_ARB_STATS_EN to add the per-port completed-packet counters (pkt_count).
module eth_port_arbiter #(
   parameter int DATAW = 148,
   parameter int SEQW  = 10
) (
   input  logic             clock,
   input  logic             sclr,
   input  logic [DATAW-1:0] in0_data,
   input  logic             in0_valid,
   input  logic             in0_startofpacket,
   input  logic             in0_endofpacket,
   input  logic             in0_empty,
   output logic             in0_ready,
   input  logic [DATAW-1:0] in1_data,
   input  logic             in1_valid,
   input  logic             in1_startofpacket,
   input  logic             in1_endofpacket,
   input  logic             in1_empty,
   output logic             in1_ready,
   input  logic [DATAW-1:0] in2_data,
   input  logic             in2_valid,
   input  logic             in2_startofpacket,
   input  logic             in2_endofpacket,
   input  logic             in2_empty,
   output logic             in2_ready,
   input  logic [DATAW-1:0] in3_data,
   input  logic             in3_valid,
   input  logic             in3_startofpacket,
   input  logic             in3_endofpacket,
   input  logic             in3_empty,
   output logic             in3_ready,
   output logic [DATAW-1:0] out_data,
   output logic             out_valid,
   output logic             out_startofpacket,
   output logic             out_endofpacket,
   output logic             out_empty,
   output logic [1:0]       out_channel,
   input  logic             out_ready,
   output logic [SEQW-1:0]  out_seq,
   input  logic             xoff,
   output logic             sop_err
`ifdef ETH_ARB_STATS_EN
   ,
   output logic [127:0]     pkt_count
`endif
);

   typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [1:0]      grant_q, grant_d;
   logic [1:0]      last_q, last_d;
   logic [1:0]      pick;
   logic [SEQW-1:0] seq_q, seq_d;
   logic            sop_err_q, sop_err_d;

   logic [DATAW-1:0] dat [4];
   logic [3:0]       vld, sop, eop, emp, rdy;
   logic [3:0]       elig, stray;
   logic             found, xfer, xfer_eop;

   assign dat[0] = in0_data;
   assign dat[1] = in1_data;
   assign dat[2] = in2_data;
   assign dat[3] = in3_data;

   assign vld = {in3_valid, in2_valid,
                 in1_valid, in0_valid};
   assign sop = {in3_startofpacket, in2_startofpacket,
                 in1_startofpacket, in0_startofpacket};
   assign eop = {in3_endofpacket, in2_endofpacket,
                 in1_endofpacket, in0_endofpacket};
   assign emp = {in3_empty, in2_empty,
                 in1_empty, in0_empty};

   assign {in3_ready, in2_ready,
           in1_ready, in0_ready} = rdy;

   assign elig  = vld & sop;
   assign stray = vld & ~sop;

   // Search upward from the port after the last winner.
   always_comb begin
      pick  = last_q;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         if (!found && elig[last_q + 2'(k)]) begin
            pick  = last_q + 2'(k);
            found = 1'b1;
         end
      end
   end

   assign xfer     = (state_q == PASS) && vld[grant_q] && out_ready;
   assign xfer_eop = xfer && eop[grant_q];

   always_ff @(posedge clock) begin
      if (sclr) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (!xoff && found) state_d = PASS;
         PASS: if (xfer_eop)       state_d = IDLE;
      endcase
   end

   always_comb begin
      rdy       = '0;
      out_valid = 1'b0;
      if (!sclr) begin
         unique case (state_q)
            IDLE: rdy = stray;
            PASS: begin
               rdy[grant_q] = out_ready;
               out_valid    = vld[grant_q];
            end
         endcase
      end
   end

   assign out_data          = dat[grant_q];
   assign out_startofpacket = sop[grant_q];
   assign out_endofpacket   = eop[grant_q];
   assign out_empty         = emp[grant_q];
   assign out_channel       = grant_q;
   assign out_seq           = seq_q;
   assign sop_err           = sop_err_q;

   always_comb begin
      grant_d   = grant_q;
      last_d    = last_q;
      seq_d     = seq_q;
      sop_err_d = (state_q == IDLE) && (|stray);
      if (state_q == IDLE && !xoff && found) grant_d = pick;
      if (xfer_eop) begin
         last_d = grant_q;
         seq_d  = seq_q + SEQW'(1);
      end
   end

   // last_q resets to 3 so port 0 wins the first arbitration.
   always_ff @(posedge clock) begin
      if (sclr) begin
         grant_q   <= 2'd0;
         last_q    <= 2'd3;
         seq_q     <= '0;
         sop_err_q <= 1'b0;
      end else begin
         grant_q   <= grant_d;
         last_q    <= last_d;
         seq_q     <= seq_d;
         sop_err_q <= sop_err_d;
      end
   end

`ifdef ETH_ARB_STATS_EN
   logic [31:0] cnt_q [4];
   logic [31:0] cnt_d [4];

   always_comb begin
      for (int p = 0; p < 4; p++) cnt_d[p] = cnt_q[p];
      if (xfer_eop && cnt_q[grant_q] != 32'hFFFF_FFFF)
         cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (sclr) begin
         for (int p = 0; p < 4; p++) cnt_q[p] <= '0;
      end else begin
         for (int p = 0; p < 4; p++) cnt_q[p] <= cnt_d[p];
      end
   end

   assign pkt_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
   // statistics counters not built
`endif

endmodule

// File: tb/tb_eth_port_arbiter.sv
// Self-checking bench for eth_port_arbiter: directed scenarios plus a
// randomized run against a packet-level round-robin reference model.
module tb_eth_port_arbiter;
   localparam int DATAW = 148;
   localparam int SEQW  = 10;

   typedef struct {
      logic [DATAW-1:0] d;
      logic             sop;
      logic             eop;
      logic             em;
   } beat_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic             sclr, xoff, ordy;
   logic [DATAW-1:0] d [4];
   logic [3:0]       v, s, e, em, en;
   wire  [3:0]       rdy;
   logic [DATAW-1:0] out_data;
   logic             out_valid, out_sop, out_eop, out_empty;
   logic [1:0]       out_channel;
   logic [SEQW-1:0]  out_seq;
   logic             sop_err;
`ifdef ETH_ARB_STATS_EN
   logic [127:0]     pkt_count;
`endif

   beat_t srcq [4][$];
   int    vecs = 0;
   int    errs = 0;

   eth_port_arbiter #(.DATAW(DATAW), .SEQW(SEQW)) dut (
      .clock             (clock),
      .sclr              (sclr),
      .in0_data          (d[0]),
      .in0_valid         (v[0]),
      .in0_startofpacket (s[0]),
      .in0_endofpacket   (e[0]),
      .in0_empty         (em[0]),
      .in0_ready         (rdy[0]),
      .in1_data          (d[1]),
      .in1_valid         (v[1]),
      .in1_startofpacket (s[1]),
      .in1_endofpacket   (e[1]),
      .in1_empty         (em[1]),
      .in1_ready         (rdy[1]),
      .in2_data          (d[2]),
      .in2_valid         (v[2]),
      .in2_startofpacket (s[2]),
      .in2_endofpacket   (e[2]),
      .in2_empty         (em[2]),
      .in2_ready         (rdy[2]),
      .in3_data          (d[3]),
      .in3_valid         (v[3]),
      .in3_startofpacket (s[3]),
      .in3_endofpacket   (e[3]),
      .in3_empty         (em[3]),
      .in3_ready         (rdy[3]),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_startofpacket (out_sop),
      .out_endofpacket   (out_eop),
      .out_empty         (out_empty),
      .out_channel       (out_channel),
      .out_ready         (ordy),
      .out_seq           (out_seq),
      .xoff              (xoff),
      .sop_err           (sop_err)
`ifdef ETH_ARB_STATS_EN
      ,
      .pkt_count         (pkt_count)
`endif
   );

   function automatic logic [DATAW-1:0] rnd_data();
      logic [DATAW-1:0] r;
      r = '0;
      for (int i = 0; i < 5; i++) r = {r[DATAW-33:0], $urandom()};
      return r;
   endfunction

   task automatic push_pkt(input int p, input int len, input bit good);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.d   = rnd_data();
         b.sop = good && (i == 0);
         b.eop = (i == len - 1);
         b.em  = 1'($urandom_range(0, 1));
         srcq[p].push_back(b);
      end
   endtask

   task automatic drive();
      for (int p = 0; p < 4; p++) begin
         if (srcq[p].size() > 0 && en[p]) begin
            d[p]  = srcq[p][0].d;
            v[p]  = 1'b1;
            s[p]  = srcq[p][0].sop;
            e[p]  = srcq[p][0].eop;
            em[p] = srcq[p][0].em;
         end else begin
            d[p]  = '0;
            v[p]  = 1'b0;
            s[p]  = 1'b0;
            e[p]  = 1'b0;
            em[p] = 1'b0;
         end
      end
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   task automatic advance();
      for (int p = 0; p < 4; p++)
         if (rdy[p] && v[p]) void'(srcq[p].pop_front());
      @(posedge clock);
      #1;
      drive();
   endtask

   task automatic clear_src();
      for (int p = 0; p < 4; p++) srcq[p].delete();
   endtask

   task automatic do_reset();
      sclr = 1'b1;
      xoff = 1'b0;
      ordy = 1'b1;
      en   = '1;
      clear_src();
      drive();
      repeat (2) @(posedge clock);
      #1;
      sclr = 1'b0;
      drive();
   endtask

   task automatic test_reset();
      sclr = 1'b1;
      xoff = 1'b0;
      ordy = 1'b1;
      en   = '1;
      clear_src();
      push_pkt(1, 2, 1'b1);
      push_pkt(2, 1, 1'b0);
      drive();
      repeat (2) @(posedge clock);
      sample();
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %0b want 0", out_valid); end
      vecs++; if (rdy !== 4'b0000) begin errs++; $display("FAIL rst_ready got %b want 0000", rdy); end
      vecs++; if (out_seq !== '0) begin errs++; $display("FAIL rst_seq got %0d want 0", out_seq); end
      vecs++; if (sop_err !== 1'b0) begin errs++; $display("FAIL rst_soperr got %0b want 0", sop_err); end
      @(posedge clock);
      #1;
      sclr = 1'b0;
      drive();
      sample();
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_idle_valid got %0b want 0", out_valid); end
      vecs++; if (rdy !== 4'b0100) begin errs++; $display("FAIL rst_idle_ready got %b want 0100", rdy); end
      vecs++; if (sop_err !== 1'b0) begin errs++; $display("FAIL rst_idle_soperr got %0b want 0", sop_err); end
      advance();
      sample();
      vecs++; if (sop_err !== 1'b1) begin errs++; $display("FAIL rst_pulse got %0b want 1", sop_err); end
      vecs++; if (out_valid !== 1'b1) begin errs++; $display("FAIL rst_first_valid got %0b want 1", out_valid); end
      vecs++; if (out_channel !== 2'd1) begin errs++; $display("FAIL rst_first_chan got %0d want 1", out_channel); end
   endtask

   task automatic test_rr_order();
      int done, ncyc;
      do_reset();
      for (int p = 0; p < 4; p++) push_pkt(p, 3, 1'b1);
      drive();
      done = 0;
      ncyc = 0;
      for (int c = 0; c < 40 && done < 4; c++) begin
         sample();
         if (out_valid && ordy) begin
            vecs++; if (out_data !== srcq[out_channel][0].d) begin errs++; $display("FAIL rr_data got %h want %h", out_data, srcq[out_channel][0].d); end
            vecs++; if (out_channel !== 2'(done)) begin errs++; $display("FAIL rr_chan got %0d want %0d", out_channel, done); end
            vecs++; if (out_seq !== SEQW'(done)) begin errs++; $display("FAIL rr_seq got %0d want %0d", out_seq, done); end
            if (out_eop) begin
               done++;
               ncyc = c + 1;
            end
         end
         advance();
      end
      vecs++; if (done != 4 || ncyc != 16) begin errs++; $display("FAIL rr_cycles got %0d pkts in %0d cycles want 4 in 16", done, ncyc); end
`ifdef ETH_ARB_STATS_EN
      sample();
      for (int p = 0; p < 4; p++) begin
         vecs++; if (pkt_count[p*32 +: 32] !== 32'd1) begin errs++; $display("FAIL rr_stats port %0d got %0d want 1", p, pkt_count[p*32 +: 32]); end
      end
`endif
   endtask

   task automatic test_back_to_back();
      int g [8];
      int gx [5];
      int ng;
      gx = '{2, 1, 2, 2, 2};
      ng = 0;
      do_reset();
      for (int i = 0; i < 4; i++) push_pkt(2, 1, 1'b1);
      drive();
      sample();
      advance();
      push_pkt(1, 2, 1'b1);
      drive();
      for (int c = 1; c < 24; c++) begin
         sample();
         if (out_valid && ordy && out_sop) begin
            if (ng < 8) g[ng] = int'(out_channel);
            ng++;
         end
         advance();
      end
      vecs++; if (ng != 5) begin errs++; $display("FAIL b2b_count got %0d want 5", ng); end
      for (int i = 0; i < 5 && i < ng; i++) begin
         vecs++; if (g[i] != gx[i]) begin errs++; $display("FAIL b2b_grant%0d got %0d want %0d", i, g[i], gx[i]); end
      end
   endtask

   task automatic test_xoff();
      bit xov;
      do_reset();
      push_pkt(0, 5, 1'b1);
      push_pkt(1, 1, 1'b1);
      drive();
      for (int c = 0; c <= 12; c++) begin
         xoff = (c >= 2 && c <= 8);
         drive();
         sample();
         xov = (c >= 1 && c <= 5) || c == 10;
         vecs++; if (out_valid !== xov) begin errs++; $display("FAIL xoff_valid c%0d got %0b want %0b", c, out_valid, xov); end
         if (xov) begin
            vecs++; if (out_channel !== (c == 10 ? 2'd1 : 2'd0)) begin errs++; $display("FAIL xoff_chan c%0d got %0d", c, out_channel); end
         end
         if (c >= 6 && c <= 9) begin
            vecs++; if (rdy !== 4'b0000) begin errs++; $display("FAIL xoff_ready c%0d got %b want 0000", c, rdy); end
         end
         advance();
      end
      xoff = 1'b0;
   endtask

   task automatic test_sop_err();
      do_reset();
      push_pkt(3, 1, 1'b0);
      drive();
      sample();
      vecs++; if (rdy !== 4'b1000) begin errs++; $display("FAIL sop_ready got %b want 1000", rdy); end
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL sop_valid0 got %0b want 0", out_valid); end
      vecs++; if (sop_err !== 1'b0) begin errs++; $display("FAIL sop_pre got %0b want 0", sop_err); end
      advance();
      sample();
      vecs++; if (sop_err !== 1'b1) begin errs++; $display("FAIL sop_pulse got %0b want 1", sop_err); end
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL sop_valid1 got %0b want 0", out_valid); end
      advance();
      sample();
      vecs++; if (sop_err !== 1'b0) begin errs++; $display("FAIL sop_end got %0b want 0", sop_err); end
      push_pkt(0, 1, 1'b0);
      push_pkt(2, 1, 1'b0);
      drive();
      sample();
      vecs++; if (rdy !== 4'b0101) begin errs++; $display("FAIL sop2_ready got %b want 0101", rdy); end
      advance();
      sample();
      vecs++; if (sop_err !== 1'b1) begin errs++; $display("FAIL sop2_pulse got %0b want 1", sop_err); end
      advance();
      sample();
      vecs++; if (sop_err !== 1'b0) begin errs++; $display("FAIL sop2_end got %0b want 0", sop_err); end
   endtask

   task automatic test_seq_wrap();
      int done, lastseq;
      do_reset();
      for (int i = 0; i < 1024; i++) push_pkt(0, 1, 1'b1);
      drive();
      done = 0;
      lastseq = -1;
      for (int c = 0; c < 3000 && done < 1024; c++) begin
         sample();
         if (out_valid && ordy) begin
            vecs++; if (out_seq !== SEQW'(done)) begin errs++; $display("FAIL wrap_seq got %0d want %0d", out_seq, done % 1024); end
            lastseq = int'(out_seq);
            done++;
         end
         advance();
      end
      vecs++; if (done != 1024) begin errs++; $display("FAIL wrap_timeout got %0d pkts want 1024", done); end
      vecs++; if (lastseq != 1023) begin errs++; $display("FAIL wrap_last got %0d want 1023", lastseq); end
      sample();
      vecs++; if (out_seq !== '0) begin errs++; $display("FAIL wrap_zero got %0d want 0", out_seq); end
`ifdef ETH_ARB_STATS_EN
      begin
         longint sum;
         sum = 0;
         for (int p = 0; p < 4; p++) sum += longint'(pkt_count[p*32 +: 32]);
         vecs++; if (sum != 1024) begin errs++; $display("FAIL wrap_stats got %0d want 1024", sum); end
      end
`endif
   endtask

   task automatic test_sclr_mid();
      do_reset();
      push_pkt(0, 1, 1'b1);
      push_pkt(1, 4, 1'b1);
      drive();
      sample();
      advance();
      sample();
      advance();
      sample();
      vecs++; if (out_seq !== SEQW'(1)) begin errs++; $display("FAIL sclr_seq1 got %0d want 1", out_seq); end
      advance();
      sample();
      advance();
      sample();
      vecs++; if (out_valid !== 1'b1 || out_channel !== 2'd1) begin errs++; $display("FAIL sclr_mid got v%0b ch%0d want v1 ch1", out_valid, out_channel); end
      advance();
      sclr = 1'b1;
      drive();
      sample();
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL sclr_valid got %0b want 0", out_valid); end
      vecs++; if (rdy !== 4'b0000) begin errs++; $display("FAIL sclr_ready got %b want 0000", rdy); end
      clear_src();
      push_pkt(0, 2, 1'b1);
      push_pkt(1, 2, 1'b1);
      advance();
      sclr = 1'b0;
      drive();
      sample();
      vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL sclr_idle got %0b want 0", out_valid); end
      vecs++; if (out_seq !== '0) begin errs++; $display("FAIL sclr_seq0 got %0d want 0", out_seq); end
      vecs++; if (rdy !== 4'b0000) begin errs++; $display("FAIL sclr_idle_ready got %b want 0000", rdy); end
      advance();
      sample();
      vecs++; if (out_valid !== 1'b1 || out_channel !== 2'd0) begin errs++; $display("FAIL sclr_regrant got v%0b ch%0d want v1 ch0", out_valid, out_channel); end
   endtask

   task automatic test_random();
      bit         busy, errx, nerr, got;
      int         chan, last, mseq, pick;
      int         waitc [4];
      int         mcnt [4];
      logic [3:0] xr, elig, stray;
      bit         xov;
      do_reset();
      busy = 1'b0;
      errx = 1'b0;
      chan = 0;
      last = 3;
      mseq = 0;
      for (int p = 0; p < 4; p++) begin
         waitc[p] = 0;
         mcnt[p]  = 0;
      end
      for (int c = 0; c < 4000; c++) begin
         for (int p = 0; p < 4; p++) begin
            if (srcq[p].size() == 0 && $urandom_range(0, 3) == 0) begin
               if ($urandom_range(0, 15) == 0) push_pkt(p, 1, 1'b0);
               else push_pkt(p, $urandom_range(1, 4), 1'b1);
            end
            en[p] = ($urandom_range(0, 7) != 0);
         end
         ordy = ($urandom_range(0, 3) != 0);
         xoff = ($urandom_range(0, 9) == 0);
         drive();
         sample();
         elig  = v & s;
         stray = v & ~s;
         xr  = busy ? (4'(ordy) << chan) : stray;
         xov = busy && v[chan];
         vecs++; if (out_valid !== xov) begin errs++; $display("FAIL rnd_valid c%0d got %0b want %0b", c, out_valid, xov); end
         vecs++; if (rdy !== xr) begin errs++; $display("FAIL rnd_ready c%0d got %b want %b", c, rdy, xr); end
         vecs++; if (out_seq !== SEQW'(mseq)) begin errs++; $display("FAIL rnd_seq c%0d got %0d want %0d", c, out_seq, mseq); end
         vecs++; if (sop_err !== errx) begin errs++; $display("FAIL rnd_soperr c%0d got %0b want %0b", c, sop_err, errx); end
         if (xov) begin
            vecs++; if (out_channel !== 2'(chan)) begin errs++; $display("FAIL rnd_chan c%0d got %0d want %0d", c, out_channel, chan); end
            vecs++; if (out_data !== srcq[chan][0].d) begin errs++; $display("FAIL rnd_data c%0d got %h want %h", c, out_data, srcq[chan][0].d); end
            vecs++; if ({out_sop, out_eop, out_empty} !== {srcq[chan][0].sop, srcq[chan][0].eop, srcq[chan][0].em}) begin
               errs++; $display("FAIL rnd_qual c%0d got %b want %b", c, {out_sop, out_eop, out_empty}, {srcq[chan][0].sop, srcq[chan][0].eop, srcq[chan][0].em});
            end
         end
         nerr = !busy && (|stray);
         if (!busy) begin
            if (!xoff && (|elig)) begin
               got  = 1'b0;
               pick = 0;
               for (int k = 1; k <= 4; k++) begin
                  if (!got && elig[(last + k) % 4]) begin
                     pick = (last + k) % 4;
                     got  = 1'b1;
                  end
               end
               for (int q = 0; q < 4; q++) begin
                  if (q == pick) waitc[q] = 0;
                  else if (elig[q]) begin
                     waitc[q]++;
                     vecs++; if (waitc[q] > 3) begin errs++; $display("FAIL rnd_starve port %0d waited %0d want <=3", q, waitc[q]); end
                  end else waitc[q] = 0;
               end
               busy = 1'b1;
               chan = pick;
            end
         end else if (v[chan] && ordy && e[chan]) begin
            busy = 1'b0;
            last = chan;
            mseq = (mseq + 1) % 1024;
            mcnt[chan]++;
         end
         errx = nerr;
         advance();
      end
      xoff = 1'b0;
      ordy = 1'b1;
      en   = '1;
`ifdef ETH_ARB_STATS_EN
      sample();
      for (int p = 0; p < 4; p++) begin
         vecs++; if (pkt_count[p*32 +: 32] !== 32'(mcnt[p])) begin errs++; $display("FAIL rnd_stats port %0d got %0d want %0d", p, pkt_count[p*32 +: 32], mcnt[p]); end
      end
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      sclr = 1'b1;
      xoff = 1'b0;
      ordy = 1'b1;
      en   = '1;
      drive();
      test_reset();
      test_rr_order();
      test_back_to_back();
      test_xoff();
      test_sop_err();
      test_seq_wrap();
      test_sclr_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/eth_port_arbiter.md
ETH_PORT_ARBITER -- requirements
Module: eth_port_arbiter

Interface
REQ-001 Parameter DATAW, default 148, beat width of every input and output data bus.
REQ-002 Parameter SEQW, default 10, width of the per-packet sequence number.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 sclr  input  1  synchronous reset, active-high.
REQ-005 inN_data  input  DATAW  port N beat (N = 0..3).
REQ-006 inN_valid / inN_startofpacket / inN_endofpacket / inN_empty  input  1 each  port N qualifiers.
REQ-007 inN_ready  output  1  port N backpressure.
REQ-008 out_data  output  DATAW  muxed beat.
REQ-009 out_valid / out_startofpacket / out_endofpacket / out_empty  output  1 each  muxed qualifiers.
REQ-010 out_channel  output  2  index of the granted port.
REQ-011 out_ready  input  1  downstream backpressure.
REQ-012 out_seq  output  SEQW  sequence number of the packet currently on out_*.
REQ-013 xoff  input  1  when high, no new packet is granted.
REQ-014 sop_err  output  1  one-cycle pulse when a stray non-SOP beat is discarded.

Function
REQ-015 Two states, IDLE and PASS; packet-granular round-robin over 4 ports.
REQ-016 IDLE: eligible ports have valid=1 and startofpacket=1; if xoff=0 and any port is eligible, grant the first eligible port searching upward (mod 4) from last_grant+1, register it in grant, go to PASS next cycle.
REQ-017 Data is not transferred in the arbitration cycle; one bubble cycle per packet.
REQ-018 IDLE: out_valid=0; inN_ready=0 for ports with valid=1 and SOP=1.
REQ-019 IDLE: a port presenting valid=1 with SOP=0 gets inN_ready=1, its beat is discarded and sop_err pulses next cycle (multiple ports in one cycle give one pulse).
REQ-020 PASS: out_* = in[grant]_* combinationally, out_channel=grant, in[grant]_ready=out_ready, every other inN_ready=0; zero-latency pass-through.
REQ-021 PASS: a beat transfers when out_valid and out_ready are both 1; a transferred beat with endofpacket=1 returns the state to IDLE, updates last_grant=grant and increments out_seq.
REQ-022 Single-beat packets (SOP and EOP in the same beat) are legal and take 2 cycles total (arbitrate + transfer).
REQ-023 SOP arriving mid-packet on the granted port is passed through unchanged.
REQ-024 xoff has no effect in PASS: the current packet always completes.
REQ-025 out_seq is constant for all beats of a packet, increments by 1 per completed packet and wraps from 2^SEQW-1 to 0.
REQ-026 Each port waits at most 3 packet grants while eligible and xoff=0 (starvation-free).

Reset
REQ-027 With sclr=1 on a rising edge: state=IDLE, last_grant=3 (port 0 highest priority next), out_seq=0, sop_err=0, statistics counters=0.
REQ-028 sclr mid-packet abandons the packet immediately with no EOP generated; out_valid=0 and all inN_ready=0 while sclr=1.

Configuration
REQ-029 Macro ETH_ARB_STATS_EN: when defined, add output pkt_count (4x32 bits, packed, port 0 in [31:0]) counting completed packets per port; each counter saturates at 2^32-1.
REQ-030 Without ETH_ARB_STATS_EN, the pkt_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-031 Ports 0-3 each hold a 3-beat packet from reset, out_ready=1 -> grant order 0,1,2,3; out_seq 0,1,2,3; 16 cycles total.
REQ-032 Port 2 streams back-to-back 1-beat packets while port 1 waits -> grants alternate 2,1,2; port 1 never waits more than one packet.
REQ-033 xoff=1 during beat 2 of a 5-beat packet on port 0 -> packet completes; no grant while xoff=1; grant one cycle after xoff falls.
REQ-034 Port 3 presents valid=1, SOP=0 in IDLE -> in3_ready=1, beat discarded, sop_err=1 for one cycle, out_valid stays 0.
REQ-035 out_seq preset by 1024 completed packets -> out_seq wraps from 1023 to 0; with ETH_ARB_STATS_EN, pkt_count sum = 1024.
REQ-036 sclr asserted mid-packet on port 1 -> next cycle IDLE, out_valid=0, out_seq=0; the next grant goes to port 0 when ports 0 and 1 are both eligible.
